mult_div: RTL
=============

# mult_div

Multicycle signed multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside the ULA, downstream of the A and B operand registers. It consumes `A_output`/`B_output` and produces `hi`/`lo` for the mem-to-reg selector (mfhi/mflo). It is started by one-cycle pulses from the control unit and signals completion so the control FSM can leave its wait state.

## Interface
- No parameters; data width fixed at 32.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_mult`  in  1  start signed multiply; sampled only when accepting.
- `start_div`  in  1  start signed divide; sampled only when accepting.
- `a_in`  in  32  multiplicand / dividend (from A register).
- `b_in`  in  32  multiplier / divisor (from B register).
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  last accepted divide had divisor 0.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - MULT, DIV: `busy`=1.
  - FINISH: `done`=1, `busy`=0.
- Accepting states are IDLE and FINISH. Starts in MULT/DIV are ignored, with no queueing.
- `start_mult` and `start_div` both high: multiply wins; divide is dropped.
- On an accepted start:
  - `a_in`/`b_in` are latched internally; later input changes have no effect.
  - Iteration counter is cleared.
  - `div_zero` is cleared, or set (see divide rules).
- MULT uses radix-2 Booth: 64+1-bit product register, 32 iterations, one per cycle.
- DIV uses restoring division on operand magnitudes:
  - 32 iterations; signs are fixed at writeback.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (`b_in`==0 at accept): no iterations; state goes straight to FINISH; `div_zero`=1; `hi`/`lo` keep their previous values.
- 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (wraps, no trap).
- `hi`/`lo` change only on the edge that enters FINISH (or on reset). They are stable otherwise, including during busy.
- `div_zero` holds until the next accepted start.
- Reset (any time, mid-op included) forces:
  - state IDLE;
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0;
  - counter and internal registers 0.
- All outputs are registered.

## Timing
- Accepted start sampled at edge N:
  - `busy`=1 from edge N.
  - Iterations occur at edges N+1..N+32.
  - Edge N+33 writes `hi`/`lo`, enters FINISH, and drops `busy`.
  - `done`=1 for exactly one cycle after edge N+33.
  - Edge N+34 returns to IDLE, unless a new start was sampled there.
- Latency from start edge to `done` high is 33 cycles, for both MULT and DIV.
- Divide by zero: FINISH is entered at edge N; `done` is high in the cycle after edge N; `busy` never rises.
- Back-to-back: a start sampled in FINISH at edge M begins a new op (`busy`=1 from M). `hi`/`lo` still hold the just-written result until that op's FINISH.
- Reset deasserting has no synchronizer requirement beyond the system's reset synchronizer. The first start is accepted on the first edge with `reset`=1.

## Configuration
- Macro: `MULT_DIV_UNSIGNED_EN`.
- Defined:
  - Adds input port `is_unsigned` (1 bit, sampled with the start).
  - When 1, operands are treated as unsigned (multu/divu); no sign correction is applied.
  - The 0x80000000/-1 special case does not apply.
  - Latency is unchanged.
- Undefined:
  - Port is absent; all operations are signed.

## Test plan
- Multiply:
  - Stimulus: `start_mult` with a=7, b=0xFFFFFFFD (−3).
  - Required: `done` exactly 33 cycles after the start edge; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for cycles 0..32.
- Multiply, large operands:
  - Stimulus: `start_mult` with a=b=0x7FFFFFFF.
  - Required: `hi`=0x3FFFFFFF, `lo`=0x00000001. Changing `a_in` mid-op must not alter the result.
- Divide:
  - Stimulus: `start_div` with a=0xFFFFFFF9 (−7), b=2.
  - Required: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Then a=0x80000000, b=0xFFFFFFFF.
  - Required: `lo`=0x80000000, `hi`=0.
- Divide by zero:
  - Stimulus: `start_div` with b=0 after a prior result of hi=1, lo=2.
  - Required: `done` one cycle after the start edge; `div_zero`=1; `hi`=1, `lo`=2 unchanged.
  - A following multiply clears `div_zero` at its start edge.
- Start conflicts:
  - Stimulus: pulse `start_div` at cycle 10 of a running multiply.
  - Required: it is ignored and the multiply result is correct.
  - Stimulus: both starts high together.
  - Required: a multiply executes.
  - Stimulus: a start sampled in FINISH.
  - Required: it begins immediately.
- Reset and unsigned mode:
  - Stimulus: assert `reset` low at cycle 15 of a divide.
  - Required: all outputs 0 immediately (asynchronous, without a clock edge); a new multiply after release completes normally.
  - Stimulus, with `MULT_DIV_UNSIGNED_EN` defined: divu 0xFFFFFFFF/2.
  - Required: `lo`=0x7FFFFFFF, `hi`=1.

Source files
------------

// File: rtl/mult_div.sv
`timescale 1ns/1ps
// mult_div: multicycle multiply/divide unit with architectural HI/LO registers.
// Multiply is radix-2 Booth over a 65-bit product register. Divide is restoring
// division on operand magnitudes, with signs applied at writeback.
// Both take 32 iterations plus one writeback cycle. A zero divisor skips
// straight to FINISH and leaves HI/LO untouched.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   start_mult   start multiply (sampled in IDLE/FINISH, wins over start_div)
//   start_div    start divide   (sampled in IDLE/FINISH)
//   is_unsigned  only with MULT_DIV_UNSIGNED_EN: treat operands as unsigned
//   a_in, b_in   multiplicand/dividend, multiplier/divisor
//   hi, lo       product[63:32]/[31:0] or remainder/quotient
//   busy         operation in progress
//   done         one-cycle completion pulse
//   div_zero     last accepted divide had a zero divisor
//
// Optional feature macro: MULT_DIV_UNSIGNED_EN (adds is_unsigned, multu/divu).
//
// state  | meaning
// IDLE   | waiting for a start
// MULT   | Booth iterations, busy
// DIV    | restoring-divide iterations, busy
// FINISH | result written, done pulse, still accepts a start
module mult_div (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
`ifdef MULT_DIV_UNSIGNED_EN
   input  logic        is_unsigned,
`endif
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

   state_t      state, state_next;
   logic [5:0]  cnt, cnt_next;
   logic [64:0] prod, prod_next;
   logic [31:0] mcand, mcand_next;
   logic [31:0] corr, corr_next;
   logic        neg_q, neg_q_next, neg_r, neg_r_next;
   logic [31:0] hi_next, lo_next;
   logic        busy_next, done_next, div_zero_next;

   logic        uns_sel;
   logic [31:0] a_mag, b_mag;
   logic [32:0] booth_sum;
   logic [32:0] div_shift;
   logic        div_take;
   logic [31:0] div_rem;

`ifdef MULT_DIV_UNSIGNED_EN
   assign uns_sel = is_unsigned;
`else
   assign uns_sel = 1'b0;
`endif

   assign a_mag = (!uns_sel && a_in[31]) ? (~a_in + 32'd1) : a_in;
   assign b_mag = (!uns_sel && b_in[31]) ? (~b_in + 32'd1) : b_in;

   // Booth add is done at 33 bits so that subtracting the most negative
   // multiplicand cannot overflow before the arithmetic shift.
   always_comb begin
      case (prod[1:0])
         2'b01:   booth_sum = {prod[64], prod[64:33]} + {mcand[31], mcand};
         2'b10:   booth_sum = {prod[64], prod[64:33]} - {mcand[31], mcand};
         default: booth_sum = {prod[64], prod[64:33]};
      endcase
   end

   // Restoring step: prod[63:32] is the partial remainder, prod[31:0] shifts
   // the dividend out and the quotient bits in.
   assign div_shift = prod[63:31];
   assign div_take  = (div_shift >= {1'b0, mcand});
   assign div_rem   = div_take ? (div_shift[31:0] - mcand) : div_shift[31:0];

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      prod_next     = prod;
      mcand_next    = mcand;
      corr_next     = corr;
      neg_q_next    = neg_q;
      neg_r_next    = neg_r;
      hi_next       = hi;
      lo_next       = lo;
      busy_next     = busy;
      done_next     = 1'b0;
      div_zero_next = div_zero;
      case (state)
         IDLE, FINISH: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            if (start_mult) begin
               state_next    = MULT;
               busy_next     = 1'b1;
               cnt_next      = 6'd0;
               prod_next     = {32'd0, b_in, 1'b0};
               mcand_next    = a_in;
               // Unsigned product = signed product + (a31 ? b : 0) + (b31 ? a : 0) in HI.
               corr_next     = uns_sel ? ((a_in[31] ? b_in : 32'd0) + (b_in[31] ? a_in : 32'd0))
                                       : 32'd0;
               neg_q_next    = 1'b0;
               neg_r_next    = 1'b0;
               div_zero_next = 1'b0;
            end else if (start_div) begin
               cnt_next      = 6'd0;
               prod_next     = {33'd0, a_mag};
               mcand_next    = b_mag;
               corr_next     = 32'd0;
               neg_q_next    = !uns_sel && (a_in[31] ^ b_in[31]);
               neg_r_next    = !uns_sel && a_in[31];
               div_zero_next = (b_in == 32'd0);
               if (b_in == 32'd0) begin
                  state_next = FINISH;
                  done_next  = 1'b1;
               end else begin
                  state_next = DIV;
                  busy_next  = 1'b1;
               end
            end
         end
         MULT: begin
            if (cnt == 6'd32) begin
               hi_next    = prod[64:33] + corr;
               lo_next    = prod[32:1];
               state_next = FINISH;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               prod_next = {booth_sum, prod[32:1]};
               cnt_next  = cnt + 6'd1;
            end
         end
         DIV: begin
            if (cnt == 6'd32) begin
               hi_next    = neg_r ? (~prod[63:32] + 32'd1) : prod[63:32];
               lo_next    = neg_q ? (~prod[31:0] + 32'd1) : prod[31:0];
               state_next = FINISH;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               prod_next = {1'b0, div_rem, prod[30:0], div_take};
               cnt_next  = cnt + 6'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         prod     <= 65'd0;
         mcand    <= 32'd0;
         corr     <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         prod     <= prod_next;
         mcand    <= mcand_next;
         corr     <= corr_next;
         neg_q    <= neg_q_next;
         neg_r    <= neg_r_next;
         hi       <= hi_next;
         lo       <= lo_next;
         busy     <= busy_next;
         done     <= done_next;
         div_zero <= div_zero_next;
      end
   end

endmodule
